fwd_ctrl_unit: RTL and testbench



---
 rtl/fwd_pkg.sv | 38 +++
 rtl/fwd_match.sv | 50 +++++
 rtl/fwd_ctrl_unit.sv | 125 ++++++++++++
 tb/tb_fwd_ctrl_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the EX-stage forwarding/stall unit.
//   - FWD_SEL_* : 3-to-1 operand mux select encoding (2'b11 is never driven)
//   - REG_ZERO  : hard-wired zero register, never a forwarding source
//   - slot_t    : per-stage shadow of the destination/source register info
package fwd_pkg;

  localparam int FWD_REG_ADDR_W = 5;
  localparam int FWD_SEL_W      = 2;

  localparam logic [FWD_SEL_W-1:0] FWD_SEL_REG = 2'b00;  // register-file value
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_WB  = 2'b01;  // MEM/WB result
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_MEM = 2'b10;  // EX/MEM result

  localparam logic [FWD_REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                      valid;
    logic [FWD_REG_ADDR_W-1:0] rs;
    logic [FWD_REG_ADDR_W-1:0] rt;
    logic                      uses_rs;
    logic                      uses_rt;
    logic [FWD_REG_ADDR_W-1:0] dst;
    logic                      reg_write;
    logic                      mem_read;
  } slot_t;

  // An empty pipeline slot; fields other than valid are don't-care.
  localparam slot_t SLOT_BUBBLE = '{
    valid: 1'b0, rs: 5'd0, rt: 5'd0, uses_rs: 1'b0, uses_rt: 1'b0,
    dst: 5'd0, reg_write: 1'b0, mem_read: 1'b0
  };

  // True when a slot produces a register value that may be forwarded to src.
  function automatic logic slot_writes(input slot_t s, input logic [FWD_REG_ADDR_W-1:0] src);
    return s.valid && s.reg_write && (s.dst != REG_ZERO) && (s.dst == src);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority compare for one EX operand against the MEM and WB slots.
// Ports:
//   ex_slot  - instruction currently in EX
//   mem_slot - instruction currently in MEM (youngest producer, highest priority)
//   wb_slot  - instruction currently in WB
//   use_rt   - 0: compare operand rs, 1: compare operand rt
//   sel      - operand mux select (FWD_SEL_REG / FWD_SEL_WB / FWD_SEL_MEM)
module fwd_match
  import fwd_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  slot_t            ex_slot,
  input  slot_t            mem_slot,
  input  slot_t            wb_slot,
  input  logic             use_rt,
  output logic [SEL_W-1:0] sel
);

  logic [FWD_REG_ADDR_W-1:0] src_s;
  logic                      uses_s;

  // Pick which EX source register this instance compares.
  always_comb begin
    src_s  = ex_slot.rs;
    uses_s = ex_slot.uses_rs;
    if (use_rt) begin
      src_s  = ex_slot.rt;
      uses_s = ex_slot.uses_rt;
    end else begin
      src_s  = ex_slot.rs;
      uses_s = ex_slot.uses_rs;
    end
  end

  // MEM beats WB so the youngest producer of a register wins.
  always_comb begin
    sel = FWD_SEL_REG;
    if (!(ex_slot.valid && uses_s)) begin
      sel = FWD_SEL_REG;
    end else if (slot_writes(mem_slot, src_s)) begin
      sel = FWD_SEL_MEM;
    end else if (slot_writes(wb_slot, src_s)) begin
      sel = FWD_SEL_WB;
    end else begin
      sel = FWD_SEL_REG;
    end
  end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// fwd_ctrl_unit: forwarding-select and load-use stall control for the 5-stage
// MIPS pipeline. Keeps a shadow EX/MEM/WB copy of register info per stage.
// Ports:
//   clk, rst_n            - clock (rising edge), asynchronous active-low reset
//   id_*                  - decoded info of the instruction in ID
//   flush                 - kill the ID instruction (taken branch/jump)
//   ex_fwd_a_sel/_b_sel   - EX operand A/B mux selects
//   stall                 - hold PC and IF/ID, insert a bubble into EX
//   stall_cnt, fwd_cnt    - saturating perf counters, only when the macro
//                           FWD_PERF_CNT_EN is defined
module fwd_ctrl_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
`ifdef FWD_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      fwd_cnt,
`endif
  output logic [SEL_W-1:0]      ex_fwd_a_sel,
  output logic [SEL_W-1:0]      ex_fwd_b_sel,
  output logic                  stall
);

  slot_t ex_r;
  slot_t mem_r;
  slot_t wb_r;
  slot_t id_slot_s;
  logic  stall_s;

  // Pack the ID-stage fields into a slot.
  always_comb begin
    id_slot_s.valid     = id_valid;
    id_slot_s.rs        = id_rs;
    id_slot_s.rt        = id_rt;
    id_slot_s.uses_rs   = id_uses_rs;
    id_slot_s.uses_rt   = id_uses_rt;
    id_slot_s.dst       = id_dst;
    id_slot_s.reg_write = id_reg_write;
    id_slot_s.mem_read  = id_mem_read;
  end

  // Load-use hazard: one bubble; flush overrides since the ID instruction dies.
  always_comb begin
    stall_s = 1'b0;
    if (id_valid && !flush && ex_r.valid && ex_r.mem_read && (ex_r.dst != REG_ZERO)) begin
      stall_s = (id_uses_rs && (id_rs == ex_r.dst)) || (id_uses_rt && (id_rt == ex_r.dst));
    end else begin
      stall_s = 1'b0;
    end
  end

  assign stall = stall_s;

  // Shadow pipeline advance; a stall or flush injects a bubble into EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r  <= SLOT_BUBBLE;
      mem_r <= SLOT_BUBBLE;
      wb_r  <= SLOT_BUBBLE;
    end else begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (!stall_s && !flush) begin
        ex_r <= id_slot_s;
      end else begin
        ex_r <= SLOT_BUBBLE;
      end
    end
  end

  fwd_match #(.SEL_W(SEL_W)) u_match_a (
    .ex_slot  (ex_r),
    .mem_slot (mem_r),
    .wb_slot  (wb_r),
    .use_rt   (1'b0),
    .sel      (ex_fwd_a_sel)
  );

  fwd_match #(.SEL_W(SEL_W)) u_match_b (
    .ex_slot  (ex_r),
    .mem_slot (mem_r),
    .wb_slot  (wb_r),
    .use_rt   (1'b1),
    .sel      (ex_fwd_b_sel)
  );

`ifdef FWD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating event counters for stalls and forwarded cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= {CNT_W{1'b0}};
      fwd_cnt   <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (((ex_fwd_a_sel != FWD_SEL_REG) || (ex_fwd_b_sel != FWD_SEL_REG)) && (fwd_cnt != CNT_MAX)) begin
        fwd_cnt <= fwd_cnt + CNT_ONE;
      end else begin
        fwd_cnt <= fwd_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Directed bench for fwd_ctrl_unit. A queue-based pipeline history model
// (newest instruction in front) predicts selects and stall every cycle;
// hand-computed literal checks pin the model on the key scenarios.
module tb_fwd_ctrl_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
  } ins_t;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_dst;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic [1:0] ex_fwd_a_sel;
  logic [1:0] ex_fwd_b_sel;
  logic       stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
  int unsigned m_stall_cnt;
  int unsigned m_fwd_cnt;
`endif

  int n_checks;
  int n_fail;

  // hist[0] = EX, hist[1] = MEM, hist[2] = WB
  ins_t hist[$];

  fwd_ctrl_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
`ifdef FWD_PERF_CNT_EN
    .stall_cnt    (stall_cnt),
    .fwd_cnt      (fwd_cnt),
`endif
    .ex_fwd_a_sel (ex_fwd_a_sel),
    .ex_fwd_b_sel (ex_fwd_b_sel),
    .stall        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected select: nearest older in-flight writer of src; distance 1 -> 2, distance 2 -> 1.
  function automatic int m_sel(input logic use_rt);
    ins_t e;
    logic [4:0] src;
    logic uses;
    e = hist[0];
    src = use_rt ? e.rt : e.rs;
    uses = use_rt ? e.urt : e.urs;
    if (!e.v || !uses) return 0;
    for (int k = 1; k <= 2; k++) begin
      if (hist[k].v && hist[k].rw && hist[k].dst != 5'd0 && hist[k].dst == src)
        return (k == 1) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic int m_stall();
    ins_t e;
    e = hist[0];
    if (!id_valid || flush || !e.v || !e.mr || e.dst == 5'd0) return 0;
    if (id_uses_rs && id_rs == e.dst) return 1;
    if (id_uses_rt && id_rt == e.dst) return 1;
    return 0;
  endfunction

  // Model: advance the history on each clock.
  always @(posedge clk) begin
    ins_t n;
    if (rst_n) begin
`ifdef FWD_PERF_CNT_EN
      if (m_stall() != 0) m_stall_cnt++;
      if (m_sel(1'b0) != 0 || m_sel(1'b1) != 0) m_fwd_cnt++;
`endif
      n = '{v: id_valid, rs: id_rs, rt: id_rt, urs: id_uses_rs, urt: id_uses_rt,
            dst: id_dst, rw: id_reg_write, mr: id_mem_read};
      if (m_stall() != 0 || flush) n = '0;
      hist.push_front(n);
      void'(hist.pop_back());
    end
  end

  // Model: asynchronous reset empties the pipeline.
  always @(negedge rst_n) begin
    hist = '{ins_t'(0), ins_t'(0), ins_t'(0)};
`ifdef FWD_PERF_CNT_EN
    m_stall_cnt = 0;
    m_fwd_cnt = 0;
`endif
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("model_a_sel", int'(ex_fwd_a_sel), m_sel(1'b0));
    chk("model_b_sel", int'(ex_fwd_b_sel), m_sel(1'b1));
    chk("model_stall", int'(stall), m_stall());
`ifdef FWD_PERF_CNT_EN
    chk("model_stall_cnt", int'(stall_cnt), int'(m_stall_cnt));
    chk("model_fwd_cnt", int'(fwd_cnt), int'(m_fwd_cnt));
`endif
  end

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic rw, input logic mr, input logic fl);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    issue(1'b1, s, t, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] d, input logic [4:0] b);
    issue(1'b1, b, 5'd0, 1'b1, 1'b0, d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    hist = '{ins_t'(0), ins_t'(0), ins_t'(0)};
`ifdef FWD_PERF_CNT_EN
    m_stall_cnt = 0;
    m_fwd_cnt = 0;
`endif
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_dst = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
    #12;
    chk("reset_a_sel", int'(ex_fwd_a_sel), 0);
    chk("reset_b_sel", int'(ex_fwd_b_sel), 0);
    chk("reset_stall", int'(stall), 0);
    rst_n = 1'b1;

    // Back-to-back: add $3<-$1,$2 ; sub $4<-$3,$5
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd4, 5'd3, 5'd5);
    nop();
    at_neg();
    chk("b2b_a_sel", int'(ex_fwd_a_sel), 2);
    chk("b2b_b_sel", int'(ex_fwd_b_sel), 0);
    chk("b2b_stall", int'(stall), 0);

    // Distance 2 double hit: add $3 ; nop ; or $6<-$3,$3
    alu(5'd3, 5'd1, 5'd2);
    nop();
    alu(5'd6, 5'd3, 5'd3);
    nop();
    at_neg();
    chk("dist2_a_sel", int'(ex_fwd_a_sel), 1);
    chk("dist2_b_sel", int'(ex_fwd_b_sel), 1);

    // Two producers in flight: MEM wins
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd3, 5'd3, 5'd1);
    alu(5'd6, 5'd3, 5'd3);
    nop();
    at_neg();
    chk("prio_a_sel", int'(ex_fwd_a_sel), 2);
    chk("prio_b_sel", int'(ex_fwd_b_sel), 2);

    // Load-use: lw $8 ; add $9<-$8,$1 (held one cycle by the stall)
    lw(5'd8, 5'd1);
    alu(5'd9, 5'd8, 5'd1);
    at_neg();
    chk("lu_stall_on", int'(stall), 1);
    alu(5'd9, 5'd8, 5'd1);
    at_neg();
    chk("lu_stall_off", int'(stall), 0);
    chk("lu_bubble_a", int'(ex_fwd_a_sel), 0);
    nop();
    at_neg();
    chk("lu_fwd_a", int'(ex_fwd_a_sel), 1);
    chk("lu_fwd_b", int'(ex_fwd_b_sel), 0);

    // Writes to $0 never forward, loads to $0 never stall
    alu(5'd0, 5'd1, 5'd2);
    alu(5'd7, 5'd0, 5'd0);
    nop();
    at_neg();
    chk("r0_a_sel", int'(ex_fwd_a_sel), 0);
    chk("r0_b_sel", int'(ex_fwd_b_sel), 0);
    lw(5'd0, 5'd1);
    alu(5'd7, 5'd0, 5'd0);
    at_neg();
    chk("r0_lw_stall", int'(stall), 0);

    // Flush during a load-use hazard
    lw(5'd8, 5'd2);
    issue(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    at_neg();
    chk("flush_stall", int'(stall), 0);
    nop();
    at_neg();
    chk("flush_a_sel", int'(ex_fwd_a_sel), 0);
    chk("flush_b_sel", int'(ex_fwd_b_sel), 0);

    // Asynchronous reset mid-cycle while forwarding from MEM
    alu(5'd3, 5'd1, 5'd2);
    alu(5'd4, 5'd3, 5'd5);
    nop();
    #2;
    chk("arst_pre_a_sel", int'(ex_fwd_a_sel), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_a_sel", int'(ex_fwd_a_sel), 0);
    chk("arst_stall", int'(stall), 0);
    #3;
    rst_n = 1'b1;
    nop();
    nop();
    at_neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
